// File: rtl/spectrum_seq_pkg.sv
// Shared types and default timing constants for the spectrum run sequencer.
package spectrum_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

    localparam int unsigned DEF_MIN_PERIOD   = 64;
    localparam int unsigned DEF_DRAIN_CYCLES = 64;

endpackage

// File: rtl/spectrum_seq_trig_sync.sv
// Two-flop synchroniser for the external trigger pin followed by a rising-edge detector.
module spectrum_seq_trig_sync (
    input  logic clk_i,
    input  logic reset_i,
    input  logic trig_i,
    output logic rise_c
);

    // [0],[1]: synchroniser stages; [2]: previous synchronised value
    logic [2:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], trig_i};
        end
    end

    assign rise_c = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/spectrum_sequencer.sv
// Run controller: issues periodic start strobes and holds enable for a configured run.
// Optional external triggering is built when SPECTRUM_SEQ_EXT_TRIG_EN is defined.
module spectrum_sequencer
    import spectrum_seq_pkg::*;
#(
    parameter int unsigned PERIOD_W     = 16,
    parameter int unsigned COUNT_W      = 32,
    parameter int unsigned MIN_PERIOD   = DEF_MIN_PERIOD,
    parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [PERIOD_W-1:0] cfg_period_i,
    input  logic [COUNT_W-1:0]  cfg_count_i,
    input  logic                abort_i,
    input  logic                ext_trig_i,
    output logic                start_o,
    output logic                enable_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [COUNT_W-1:0]  events_sent_o
);

    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

    seq_state_t          state, state_n;
    logic [PERIOD_W-1:0] cnt, cnt_n;
    logic [PERIOD_W-1:0] p_eff_q, p_eff_n, p_eff_c;
    logic [COUNT_W-1:0]  count_q, count_n;
    logic                cont_q, cont_n;
    logic [DRAIN_W-1:0]  drain_cnt, drain_n;
    logic [COUNT_W-1:0]  events_n, events_inc_c;
    logic                start_n, done_n;
    logic                fire_c, last_c;
    logic                trig_rise_c;

`ifdef SPECTRUM_SEQ_EXT_TRIG_EN
    spectrum_seq_trig_sync u_trig_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .trig_i  (ext_trig_i),
        .rise_c  (trig_rise_c)
    );
`else
    logic unused_ext_trig;
    assign unused_ext_trig = ext_trig_i;
    assign trig_rise_c     = 1'b1;
`endif

    assign p_eff_c = (cfg_period_i < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : cfg_period_i;
    assign events_inc_c = (events_sent_o == '1) ? events_sent_o : events_sent_o + COUNT_W'(1);
    // cnt counts down to zero after each start; zero means the next start slot is open
    assign fire_c = (cnt == '0) && trig_rise_c;
    assign last_c = start_o && !cont_q && (events_sent_o == count_q);

    // Next-state and next-output logic
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        p_eff_n  = p_eff_q;
        count_n  = count_q;
        cont_n   = cont_q;
        drain_n  = drain_cnt;
        events_n = events_sent_o;
        start_n  = 1'b0;
        done_n   = 1'b0;

        case (state)
            IDLE: begin
                if (cfg_valid_i && cfg_ready_o) begin
                    state_n  = RUN;
                    p_eff_n  = p_eff_c;
                    count_n  = cfg_count_i;
                    cont_n   = (cfg_count_i == '0);
                    cnt_n    = '0;
                    events_n = '0;
`ifndef SPECTRUM_SEQ_EXT_TRIG_EN
                    // Periodic runs fire their first start on the acceptance edge
                    start_n  = 1'b1;
                    cnt_n    = p_eff_c - PERIOD_W'(1);
                    events_n = COUNT_W'(1);
`endif
                end
            end
            RUN: begin
                if (abort_i || last_c) begin
                    state_n = DRAIN;
                    drain_n = '0;
                end else if (fire_c) begin
                    start_n  = 1'b1;
                    cnt_n    = p_eff_q - PERIOD_W'(1);
                    events_n = events_inc_c;
                end else if (cnt != '0) begin
                    cnt_n = cnt - PERIOD_W'(1);
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    drain_n = drain_cnt + DRAIN_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state         <= IDLE;
            cnt           <= '0;
            p_eff_q       <= '0;
            count_q       <= '0;
            cont_q        <= 1'b0;
            drain_cnt     <= '0;
            events_sent_o <= '0;
            start_o       <= 1'b0;
            enable_o      <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            cfg_ready_o   <= 1'b1;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            p_eff_q       <= p_eff_n;
            count_q       <= count_n;
            cont_q        <= cont_n;
            drain_cnt     <= drain_n;
            events_sent_o <= events_n;
            start_o       <= start_n;
            enable_o      <= (state_n != IDLE);
            busy_o        <= (state_n != IDLE);
            done_o        <= done_n;
            cfg_ready_o   <= (state_n == IDLE);
        end
    end

endmodule

// File: tb/tb_spectrum_sequencer.sv
// Directed self-checking bench for spectrum_sequencer (periodic build, or
// external-trigger build when SPECTRUM_SEQ_EXT_TRIG_EN is defined).
module tb_spectrum_sequencer;

    localparam int unsigned PERIOD_W = 16;
    localparam int unsigned COUNT_W  = 32;

    logic                clk_i = 1'b0;
    logic                reset_i = 1'b0;
    logic                cfg_valid_i = 1'b0;
    logic                cfg_ready_o;
    logic [PERIOD_W-1:0] cfg_period_i = '0;
    logic [COUNT_W-1:0]  cfg_count_i = '0;
    logic                abort_i = 1'b0;
    logic                ext_trig_i = 1'b0;
    logic                start_o, enable_o, busy_o, done_o;
    logic [COUNT_W-1:0]  events_sent_o;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    spectrum_sequencer dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .cfg_valid_i   (cfg_valid_i),
        .cfg_ready_o   (cfg_ready_o),
        .cfg_period_i  (cfg_period_i),
        .cfg_count_i   (cfg_count_i),
        .abort_i       (abort_i),
        .ext_trig_i    (ext_trig_i),
        .start_o       (start_o),
        .enable_o      (enable_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .events_sent_o (events_sent_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge
    task automatic step();
        @(negedge clk_i);
    endtask

    typedef struct {
        int period;
        int count;
        int abort_off;   // accept-relative posedge at which abort is sampled, 0 = none
        bit hold;        // keep cfg_valid high with another period during the run
        int exp_starts;
        int exp_gap;
        int exp_done;    // accept-relative cycle of the done pulse
    } vec_t;

`ifndef SPECTRUM_SEQ_EXT_TRIG_EN
    task automatic run_vec(input int idx, input vec_t v);
        int   ta;
        int   starts[$];
        int   done_at;
        int   n_done;
        int   ready_bad;
        bit   en_prev;
        bit   en_before;
        bit   en_done;
        bit   rdy_done;
        longint ev_done;
        done_at = -1; n_done = 0; ready_bad = 0; en_prev = 1'b0;
        en_before = 1'b0; en_done = 1'b1; rdy_done = 1'b0; ev_done = -1;

        cfg_period_i = PERIOD_W'(v.period);
        cfg_count_i  = COUNT_W'(v.count);
        cfg_valid_i  = 1'b1;
        step();
        ta = cyc;
        if (v.hold) cfg_period_i = PERIOD_W'(200);
        else        cfg_valid_i  = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            if (start_o) starts.push_back(cyc - ta);
            if (busy_o && cfg_ready_o) ready_bad++;
            if (done_o) begin
                n_done++;
                done_at   = cyc - ta;
                ev_done   = longint'(events_sent_o);
                rdy_done  = cfg_ready_o;
                en_done   = enable_o;
                en_before = en_prev;
                break;
            end
            en_prev     = enable_o;
            abort_i     = (v.abort_off != 0) && (cyc + 1 == ta + v.abort_off);
            ext_trig_i  = 1'($urandom_range(0, 1));
            step();
        end
        cfg_valid_i = 1'b0;
        abort_i     = 1'b0;
        ext_trig_i  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (done_o) n_done++;
            if (start_o) starts.push_back(cyc - ta);
        end

        check($sformatf("v%0d start count", idx), starts.size(), v.exp_starts);
        if (starts.size() > 0) check($sformatf("v%0d first start", idx), starts[0], 0);
        for (int i = 1; i < starts.size(); i++)
            check($sformatf("v%0d gap %0d", idx, i), starts[i] - starts[i-1], v.exp_gap);
        check($sformatf("v%0d done cycle", idx), done_at, v.exp_done);
        check($sformatf("v%0d done pulses", idx), n_done, 1);
        check($sformatf("v%0d events_sent", idx), ev_done, v.exp_starts);
        check($sformatf("v%0d ready at done", idx), rdy_done, 1);
        check($sformatf("v%0d enable at done", idx), en_done, 0);
        check($sformatf("v%0d enable before done", idx), en_before, 1);
        check($sformatf("v%0d ready while busy", idx), ready_bad, 0);
    endtask
`endif

    vec_t vecs[7];
    int   ta_main;
    int   cnt_a;
    int   cnt_b;
    int   c0;
    int   ext_q[$];

    initial begin
        vecs[0] = '{100, 3,   0, 1'b0, 3, 100, 265};
        vecs[1] = '{10,  2,   0, 1'b0, 2, 64,  129};
        vecs[2] = '{64,  0, 320, 1'b0, 5, 64,  384};
        vecs[3] = '{80,  2,   0, 1'b1, 2, 80,  145};
        vecs[4] = '{0,   1,   0, 1'b0, 1, 0,   65};
        vecs[5] = '{65,  2,   0, 1'b0, 2, 65,  130};
        vecs[6] = '{100, 0, 150, 1'b0, 2, 100, 214};

        // Reset values
        reset_i = 1'b0;
        repeat (3) step();
        check("reset start", start_o, 0);
        check("reset enable", enable_o, 0);
        check("reset busy", busy_o, 0);
        check("reset done", done_o, 0);
        check("reset events", events_sent_o, 0);
        check("reset ready", cfg_ready_o, 1);
        reset_i = 1'b1;
        step();
        check("post-reset ready", cfg_ready_o, 1);

        // Abort while idle does nothing
        abort_i = 1'b1;
        repeat (3) step();
        abort_i = 1'b0;
        check("idle abort busy", busy_o, 0);
        check("idle abort ready", cfg_ready_o, 1);
        check("idle abort enable", enable_o, 0);

`ifndef SPECTRUM_SEQ_EXT_TRIG_EN
        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Reset in the cycle a start is due: start and enable drop, no done afterwards
        cfg_period_i = PERIOD_W'(64);
        cfg_count_i  = '0;
        cfg_valid_i  = 1'b1;
        step();
        ta_main     = cyc;
        cfg_valid_i = 1'b0;
        repeat (127) step();
        check("midrun events", events_sent_o, 2);
        check("midrun busy", busy_o, 1);
        reset_i = 1'b0;
        step();
        check("midrun reset start", start_o, 0);
        check("midrun reset enable", enable_o, 0);
        check("midrun reset busy", busy_o, 0);
        check("midrun reset ready", cfg_ready_o, 1);
        check("midrun reset events", events_sent_o, 0);
        reset_i = 1'b1;
        cnt_a = 0; cnt_b = 0;
        repeat (150) begin
            step();
            if (done_o) cnt_a++;
            if (start_o || enable_o) cnt_b++;
        end
        check("midrun no done", cnt_a, 0);
        check("midrun stays idle", cnt_b, 0);
`else
        // External trigger: first start waits for an edge; close edges are dropped
        cfg_period_i = PERIOD_W'(10);
        cfg_count_i  = '0;
        cfg_valid_i  = 1'b1;
        step();
        cfg_valid_i = 1'b0;
        cnt_a = 0;
        repeat (20) begin
            step();
            if (start_o) cnt_a++;
        end
        check("ext no start without edge", cnt_a, 0);
        check("ext busy", busy_o, 1);
        c0 = cyc;
        for (int k = 0; k < 120; k++) begin
            ext_trig_i = (k == 0 || k == 1 || k == 10 || k == 11 ||
                          k == 40 || k == 41 || k == 70 || k == 71);
            step();
            if (start_o) ext_q.push_back(cyc - c0);
        end
        ext_trig_i = 1'b0;
        check("ext start count", ext_q.size(), 2);
        if (ext_q.size() > 0) check("ext first latency", ext_q[0], 3);
        if (ext_q.size() > 1) check("ext second start", ext_q[1], 73);
        check("ext events", events_sent_o, 2);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        cnt_a = 0;
        for (int c = 0; c < 200; c++) begin
            step();
            if (done_o) begin
                cnt_a = 1;
                break;
            end
        end
        check("ext done after abort", cnt_a, 1);
        check("ext ready after done", cfg_ready_o, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
